// File: rtl/arm_pipe_pkg.sv
// Shared encodings for the MEM-stage data-memory unit: FSM states, size/rw codes
// and the byte-lane helpers used to place store data on the RAM write bus.
package arm_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;
    localparam logic RW_LOAD   = 1'b0;
    localparam logic RW_STORE  = 1'b1;

    // Lane 3 (bits 31:24) is the byte at the access address in big-endian order
    function automatic logic [3:0] lane_en(input logic size);
        return (size == SIZE_WORD) ? 4'b1111 : 4'b1000;
    endfunction

    function automatic logic [31:0] lane_data(input logic size, input logic [31:0] d);
        return (size == SIZE_WORD) ? d : {d[7:0], 24'h00_0000};
    endfunction

endpackage

// File: rtl/data_ram_core.sv
// Byte-array data RAM: synchronous 4-byte big-endian write with per-lane enable
// and combinational 4-byte read; byte offsets wrap modulo the RAM depth.
module data_ram_core #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [7:0] Mem [0:2**ADDR_W-1];

    // Write: lane 3 goes to addr, lane 0 to addr+3 (contents are never reset)
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[3-i]) begin
                    Mem[addr + ADDR_W'(i)] <= wdata[31-8*i -: 8];
                end
            end
        end
    end

    // Read: assemble four consecutive bytes, most significant first
    always_comb begin
        rdata = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            rdata[31-8*i -: 8] = Mem[addr + ADDR_W'(i)];
        end
    end

endmodule

// File: rtl/data_mem_stage.sv
// MEM-stage data-memory access unit with WAIT_CYC wait states and pipeline stall.
// Optional macro DMEM_ALIGN_CHECK_EN: unaligned word accesses are dropped and flagged on align_err.
module data_mem_stage
    import arm_pipe_pkg::*;
#(
    parameter int WAIT_CYC = 2,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              R,
    input  logic              mem_en,
    input  logic              mem_rw,
    input  logic              mem_size,
    input  logic              mem_load,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              align_err
);

    localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
    localparam logic       HAS_WAIT = (WAIT_CYC > 0) ? 1'b1 : 1'b0;

    state_e            state_r;
    state_e            state_nxt_s;
    logic [3:0]        cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic              rw_r;
    logic              size_r;
    logic              load_r;

    logic [ADDR_W-1:0] req_addr_s;
    logic [31:0]       req_wdata_s;
    logic              req_rw_s;
    logic              req_size_s;
    logic              req_load_s;
    logic              accept_s;
    logic              finish_s;
    logic              align_bad_s;
    logic              ram_we_s;
    logic [31:0]       ram_rdata_s;

    assign accept_s = (state_r == IDLE) && mem_en;
    assign finish_s = (state_nxt_s == DONE);

    // Accepting IDLE cycle uses the live inputs; later cycles use the latched copy
    always_comb begin
        if (state_r == IDLE) begin
            req_addr_s  = addr;
            req_wdata_s = wdata;
            req_rw_s    = mem_rw;
            req_size_s  = mem_size;
            req_load_s  = mem_load;
        end else begin
            req_addr_s  = addr_r;
            req_wdata_s = wdata_r;
            req_rw_s    = rw_r;
            req_size_s  = size_r;
            req_load_s  = load_r;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign align_bad_s = (req_size_s == SIZE_WORD) && (req_addr_s[1:0] != 2'b00);
`else
    assign align_bad_s = 1'b0;
`endif

    // R gates the write so a request seen during reset can never touch the RAM
    assign ram_we_s = finish_s && (req_rw_s == RW_STORE) && !align_bad_s && R;

    data_ram_core #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .be    (lane_en(req_size_s)),
        .addr  (req_addr_s),
        .wdata (lane_data(req_size_s, req_wdata_s)),
        .rdata (ram_rdata_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (mem_en) begin
                    state_nxt_s = HAS_WAIT ? ACCESS : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: stall is low in DONE so the pipeline advances on that edge
    always_comb begin
        stall = 1'b0;
        case (state_r)
            IDLE:    stall = R && mem_en;
            ACCESS:  stall = R;
            DONE:    stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    // Wait-state counter and request latch
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            cnt_r   <= 4'd0;
            addr_r  <= '0;
            wdata_r <= 32'h0000_0000;
            rw_r    <= RW_LOAD;
            size_r  <= SIZE_BYTE;
            load_r  <= 1'b0;
        end else if (accept_s) begin
            cnt_r   <= CNT_INIT;
            addr_r  <= addr;
            wdata_r <= wdata;
            rw_r    <= mem_rw;
            size_r  <= mem_size;
            load_r  <= mem_load;
        end else if ((state_r == ACCESS) && (cnt_r != 4'd0)) begin
            cnt_r   <= cnt_r - 4'd1;
        end
    end

    // Registered completion pulse and load result
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            done  <= 1'b0;
            rdata <= 32'h0000_0000;
        end else begin
            done <= finish_s;
            if (finish_s && (req_rw_s == RW_LOAD) && req_load_s && !align_bad_s) begin
                rdata <= (req_size_s == SIZE_WORD) ? ram_rdata_s
                                                   : {24'h00_0000, ram_rdata_s[31:24]};
            end
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    // Misalignment pulse coincides with done
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            align_err <= 1'b0;
        end else begin
            align_err <= finish_s && align_bad_s;
        end
    end
`else
    assign align_err = 1'b0;
`endif

endmodule
